// File: rtl/ttl_138_strobe_arbiter.sv
// ---------------------------------------------------------------------------
// ttl_138_strobe_arbiter
//
// Arbitrates eight level requests onto a 74138 3-to-8 decoder. A winner's
// code is presented on the C,B,A pins for one setup cycle. The active-low
// G2An strobe is then pulsed for PULSE_W cycles. An optional guard gap of
// GAP_W cycles follows, during which the address is still held. The winner
// gets a one-cycle ack on the first cycle after the strobe releases.
//
// Configuration macro:
//   STROBE_ROUND_ROBIN_EN  defined   -> round-robin arbitration with a
//                                       rotating priority pointer
//                          undefined -> fixed priority, req[0] highest
//
// Parameters:
//   PULSE_W    strobe low width in cycles, 1..15
//   GAP_W      idle guard width after the strobe in cycles, 0..15
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req        level requests; bit i asks for decoder output Y[i]
//   inhibit    blocks new grants (only looked at while idle)
//   dec_a      select code to decoder C,B,A
//   dec_g1     decoder G1 enable (active high)
//   dec_g2a_n  decoder G2An strobe (active low)
//   ack        one-hot, one-cycle completion pulse per requester
//   busy       high whenever a transaction is in progress
//
// Every output is a flop. No input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ttl_138_strobe_arbiter #(
   parameter int unsigned PULSE_W = 2,
   parameter int unsigned GAP_W   = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] req,
   input  logic       inhibit,
   output logic [2:0] dec_a,
   output logic       dec_g1,
   output logic       dec_g2a_n,
   output logic [7:0] ack,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      GAP    = 2'd3
   } state_t;

   // The counters load "cycles remaining minus one" on state entry. The
   // state is left on the cycle the counter reads zero.
   localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
   localparam logic [3:0] GAP_LD   = (GAP_W == 0) ? 4'd0 : 4'(GAP_W - 1);

   state_t     state;
   logic [3:0] cnt;
   // Low for the first edge after reset release. The earliest grant
   // therefore lands on the second rising edge.
   logic       armed;

   logic       win_vld;
   logic [2:0] win_idx;

`ifdef STROBE_ROUND_ROBIN_EN
   logic [2:0] ptr;

   // Scan from the farthest slot back toward the pointer. The requester
   // closest to the pointer (inclusive) overwrites the others and wins.
   always_comb begin
      // NOTE: default every combinational output first so no path can
      // leave a value unassigned and infer a latch.
      win_vld = 1'b0;
      win_idx = ptr;
      for (int k = 7; k >= 0; k--) begin
         if (req[3'(ptr + 3'(k))]) begin
            win_vld = 1'b1;
            win_idx = 3'(ptr + 3'(k));
         end
      end
   end
`else
   // Fixed priority: the lowest set index wins.
   always_comb begin
      // NOTE: default every combinational output first so no path can
      // leave a value unassigned and infer a latch.
      win_vld = 1'b0;
      win_idx = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (req[k]) begin
            win_vld = 1'b1;
            win_idx = 3'(k);
         end
      end
   end
`endif

   // A single sequencer computes every output from the state being entered.
   // This keeps all outputs registered and aligned with the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every flop samples pre-edge values regardless of statement order.
         state     <= IDLE;
         cnt       <= 4'd0;
         armed     <= 1'b0;
         dec_a     <= 3'd0;
         dec_g1    <= 1'b0;
         dec_g2a_n <= 1'b1;
         ack       <= 8'd0;
         busy      <= 1'b0;
`ifdef STROBE_ROUND_ROBIN_EN
         ptr       <= 3'd0;
`endif
      end else begin
         armed <= 1'b1;
         ack   <= 8'd0;
         unique case (state)
            IDLE: begin
               if (armed && !inhibit && win_vld) begin
                  state  <= SETUP;
                  dec_a  <= win_idx;
                  dec_g1 <= 1'b1;
                  busy   <= 1'b1;
`ifdef STROBE_ROUND_ROBIN_EN
                  ptr    <= win_idx + 3'd1;
`endif
               end
            end
            SETUP: begin
               state     <= STROBE;
               dec_g2a_n <= 1'b0;
               cnt       <= PULSE_LD;
            end
            STROBE: begin
               if (cnt == 4'd0) begin
                  dec_g2a_n <= 1'b1;
                  ack       <= 8'd1 << dec_a;
                  if (GAP_W == 0) begin
                     state  <= IDLE;
                     dec_g1 <= 1'b0;
                     busy   <= 1'b0;
                  end else begin
                     state <= GAP;
                     cnt   <= GAP_LD;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            GAP: begin
               if (cnt == 4'd0) begin
                  state  <= IDLE;
                  dec_g1 <= 1'b0;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ttl_138_strobe_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for ttl_138_strobe_arbiter. Two instances share all inputs:
//   A: PULSE_W=2, GAP_W=1 (defaults)
//   B: PULSE_W=1, GAP_W=0
// The reference model describes each transaction by the number of edges
// since its grant (t). t=0 is setup, 1..P is strobe, P+1..P+G is gap, and
// ack fires at t=P+1. The model's outputs are compared on every negedge.
// Directed scenarios pin literal values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ttl_138_strobe_arbiter;

   localparam int PA = 2, GA = 1, PB = 1, GB = 0;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] req;
   logic       inhibit;

   logic [2:0] a_dec_a,  b_dec_a;
   logic       a_g1,     b_g1;
   logic       a_g2a_n,  b_g2a_n;
   logic [7:0] a_ack,    b_ack;
   logic       a_busy,   b_busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ttl_138_strobe_arbiter #(.PULSE_W(PA), .GAP_W(GA)) dut_a (
      .clk(clk), .reset_n(reset_n), .req(req), .inhibit(inhibit),
      .dec_a(a_dec_a), .dec_g1(a_g1), .dec_g2a_n(a_g2a_n),
      .ack(a_ack), .busy(a_busy));

   ttl_138_strobe_arbiter #(.PULSE_W(PB), .GAP_W(GB)) dut_b (
      .clk(clk), .reset_n(reset_n), .req(req), .inhibit(inhibit),
      .dec_a(b_dec_a), .dec_g1(b_g1), .dec_g2a_n(b_g2a_n),
      .ack(b_ack), .busy(b_busy));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_valid[2] = '{0, 0};
   int m_t[2]     = '{0, 0};
   int m_a[2]     = '{0, 0};
   int m_ptr[2]   = '{0, 0};
   bit m_armed[2] = '{0, 0};

   function automatic int pw(int i); return (i == 0) ? PA : PB; endfunction
   function automatic int gw(int i); return (i == 0) ? GA : GB; endfunction

   function automatic bit model_busy(int i);
      return m_valid[i] && (m_t[i] <= pw(i) + gw(i));
   endfunction

   function automatic int pick(logic [7:0] r, int p);
`ifdef STROBE_ROUND_ROBIN_EN
      for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
`else
      for (int k = 0; k < 8; k++) if (r[k]) return k;
`endif
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            m_valid[i] = 0; m_t[i] = 0; m_a[i] = 0; m_ptr[i] = 0; m_armed[i] = 0;
         end else begin
            if (!model_busy(i) && m_armed[i] && !inhibit && req != 8'd0) begin
               m_a[i]     = pick(req, m_ptr[i]);
               m_ptr[i]   = (m_a[i] + 1) % 8;
               m_t[i]     = 0;
               m_valid[i] = 1;
            end else if (m_valid[i]) begin
               m_t[i]++;
               if (m_t[i] > pw(i) + gw(i) + 1) m_valid[i] = 0;
            end
            m_armed[i] = 1;
         end
      end
   end

   task automatic cmp(input int i, input string tag, input logic [2:0] da, input logic g1,
                      input logic g2n, input logic [7:0] ak, input logic bz);
      bit in_strobe;
      bit ack_now;
      in_strobe = m_valid[i] && m_t[i] >= 1 && m_t[i] <= pw(i);
      ack_now   = m_valid[i] && m_t[i] == pw(i) + 1;
      check({tag, ".busy"},      bz,  model_busy(i));
      check({tag, ".dec_g1"},    g1,  model_busy(i));
      check({tag, ".dec_g2a_n"}, g2n, !in_strobe);
      check({tag, ".ack"},       ak,  ack_now ? (32'd1 << m_a[i]) : 32'd0);
      check({tag, ".dec_a"},     da,  m_a[i]);
   endtask

   always @(negedge clk) begin
      cmp(0, "A", a_dec_a, a_g1, a_g2a_n, a_ack, a_busy);
      cmp(1, "B", b_dec_a, b_g1, b_g2a_n, b_ack, b_busy);
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int ack7_n, ack0_n, n, last, cyc;
      reset_n = 1'b0; req = 8'd0; inhibit = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dec_g2a_n", a_g2a_n, 1);
      check("rst_dec_g1",    a_g1,    0);
      check("rst_busy",      a_busy,  0);
      check("rst_ack",       a_ack,   0);
      check("rst_dec_a",     a_dec_a, 0);

      // The first edge after release only arms. The grant lands on the second.
      #1 reset_n = 1'b1; req = 8'h08;
      @(negedge clk); check("arm_no_grant", a_busy, 0);
      @(negedge clk); check("first_grant_busy", a_busy, 1);
      check("first_grant_dec_a", a_dec_a, 3);
      #1 req = 8'd0;
      repeat (8) @(negedge clk);

      // Single transaction on A (P=2, G=1). req drops after the grant.
      #1 req = 8'h08;
      @(negedge clk);
      check("s1_busy", a_busy, 1); check("s1_dec_a", a_dec_a, 3);
      check("s1_g1", a_g1, 1);     check("s1_g2a_n", a_g2a_n, 1);
      #1 req = 8'd0;
      @(negedge clk); check("s2_g2a_n", a_g2a_n, 0);
      @(negedge clk); check("s3_g2a_n", a_g2a_n, 0); check("s3_ack", a_ack, 0);
      @(negedge clk); check("s4_ack", a_ack, 8'h08); check("s4_g2a_n", a_g2a_n, 1);
      check("s4_busy", a_busy, 1); check("s4_dec_a", a_dec_a, 3);
      @(negedge clk); check("s5_busy", a_busy, 0); check("s5_ack", a_ack, 0);
      check("s5_g1", a_g1, 0);
      repeat (4) @(negedge clk);

      // B (P=1, G=0): ack arrives on IDLE re-entry, and the period is 3.
      #1 req = 8'h04;
      @(negedge clk); check("b1_busy", b_busy, 1);
      @(negedge clk); check("b2_g2a_n", b_g2a_n, 0);
      @(negedge clk); check("b3_ack", b_ack, 8'h04); check("b3_busy", b_busy, 0);
      @(negedge clk); check("b4_regrant", b_busy, 1);
      @(negedge clk);
      @(negedge clk); check("b6_ack", b_ack, 8'h04);
      #1 req = 8'd0;
      repeat (8) @(negedge clk);

      // Arbitration policy starting from a fresh reset.
      #1 reset_n = 1'b0;
      @(negedge clk);
      #1 reset_n = 1'b1;
`ifdef STROBE_ROUND_ROBIN_EN
      req = 8'hFF; n = 0; last = 0; cyc = 0;
      repeat (60) begin
         @(negedge clk);
         if (a_ack != 8'd0 && n < 9) begin
            check($sformatf("rr_order%0d", n), a_ack, 32'd1 << (n % 8));
            if (n > 0) check("rr_period", cyc - last, 5);
            last = cyc; n++;
         end
         cyc++;
      end
      check("rr_grants", n, 9);
`else
      req = 8'h81; ack7_n = 0; ack0_n = 0;
      repeat (45) begin
         @(negedge clk);
         if (a_ack[7]) ack7_n++;
         if (a_ack[0]) ack0_n++;
      end
      check("fixed_no_ack7", ack7_n, 0);
      check("fixed_ack0_grants", ack0_n >= 7, 1);
`endif
      #1 req = 8'd0;
      repeat (8) @(negedge clk);

      // Inhibit blocks grants while idle and is ignored mid-transaction.
      #1 inhibit = 1'b1; req = 8'h01;
      repeat (6) begin @(negedge clk); check("inh_busy", a_busy, 0); end
      #1 inhibit = 1'b0;
      @(negedge clk); check("inh_setup", a_busy, 1);
      @(negedge clk); check("inh_strobe", a_g2a_n, 0);
      #1 inhibit = 1'b1;
      @(negedge clk);
      @(negedge clk); check("inh_ack", a_ack, 8'h01);
      @(negedge clk); check("inh_idle", a_busy, 0);
      @(negedge clk); check("inh_no_regrant", a_busy, 0);
      #1 inhibit = 1'b0; req = 8'd0;
      repeat (4) @(negedge clk);

      // Reset during the strobe releases the strobe at once, with no ack.
      #1 req = 8'h01;
      @(negedge clk);
      @(negedge clk); check("rs_in_strobe", a_g2a_n, 0);
      #1 reset_n = 1'b0;
      #1 check("rs_g2a_n", a_g2a_n, 1); check("rs_g1", a_g1, 0);
      check("rs_busy", a_busy, 0); check("rs_ack", a_ack, 0);
      @(negedge clk); check("rs_ack_later", a_ack, 0);
      #1 reset_n = 1'b1; req = 8'd0;
      repeat (4) @(negedge clk);

      // Randomised traffic, with occasional inhibit and reset pulses.
      repeat (2000) begin
         @(negedge clk);
         #1;
         case ($urandom_range(0, 3))
            0:       req = 8'd0;
            1:       req = 8'd1 << $urandom_range(0, 7);
            default: req = 8'($urandom);
         endcase
         inhibit = ($urandom_range(0, 7) == 0);
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      end
      #1 reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
